// File: rtl/soc_gpio_display.sv
// Board I/O peripheral: software-written HEX/LED registers, seven-segment decode,
// switch synchronizer and KEY[1] debouncer with a sticky press flag.
module soc_gpio_display #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic [9:0]  sw_in,
  input  logic        key_in,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5,
  output logic [9:0]  ledr
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [23:0]   hex_value;
  logic [11:0]   hex_ctrl;
  logic [9:0]    led_reg;
  logic [9:0]    sw_meta, sw_sync;
  logic          key_meta, key_sync;
  logic          key_state;
  logic [CW-1:0] db_count;
  logic          press_flag;
  logic [31:0]   read_data;
  logic          request;
  logic          key_accept;
  logic          press_set;
  logic          press_clear;
  logic [7:0]    hex_pat [6];

  assign request     = bus_wen | bus_ren;
  assign key_accept  = (key_sync != key_state) && (db_count == CNT_MAX);
  assign press_set   = key_accept && key_sync;
  assign press_clear = bus_wen && (bus_addr == 4'h4) && bus_wdata[1];

  // Active-high segment font, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] seg_font(input logic [3:0] n);
    case (n)
      4'h0: seg_font = 7'h3F;
      4'h1: seg_font = 7'h06;
      4'h2: seg_font = 7'h5B;
      4'h3: seg_font = 7'h4F;
      4'h4: seg_font = 7'h66;
      4'h5: seg_font = 7'h6D;
      4'h6: seg_font = 7'h7D;
      4'h7: seg_font = 7'h07;
      4'h8: seg_font = 7'h7F;
      4'h9: seg_font = 7'h6F;
      4'hA: seg_font = 7'h77;
      4'hB: seg_font = 7'h7C;
      4'hC: seg_font = 7'h39;
      4'hD: seg_font = 7'h5E;
      4'hE: seg_font = 7'h79;
      default: seg_font = 7'h71;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hex_pat[i] = hex_ctrl[i] ? {~hex_ctrl[6+i], ~seg_font(hex_value[4*i +: 4])} : 8'hFF;
    end
  end

  assign hex0 = hex_pat[0];
  assign hex1 = hex_pat[1];
  assign hex2 = hex_pat[2];
  assign hex3 = hex_pat[3];
  assign hex4 = hex_pat[4];
  assign hex5 = hex_pat[5];
  assign ledr = led_reg;

  always_comb begin
    read_data = 32'h0;
    case (bus_addr)
      4'h0: read_data = {8'h0, hex_value};
      4'h1: read_data = {20'h0, hex_ctrl};
      4'h2: read_data = {22'h0, led_reg};
      4'h3: read_data = {22'h0, sw_sync};
      4'h4: read_data = {30'h0, press_flag, key_state};
      default: read_data = 32'h0;
    endcase
  end

  // Reads capture the pre-edge register value, so a combined read/write returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_value <= '0;
      hex_ctrl  <= '0;
      led_reg   <= '0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= request;
      bus_rdata <= (request && bus_ren) ? read_data : 32'h0;
      if (bus_wen) begin
        case (bus_addr)
          4'h0: hex_value <= bus_wdata[23:0];
          4'h1: hex_ctrl  <= bus_wdata[11:0];
          4'h2: led_reg   <= bus_wdata[9:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      key_meta <= ~key_in;
      key_sync <= key_meta;
    end
  end

  // A press that completes on the same edge as a clear write keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_state  <= 1'b0;
      db_count   <= '0;
      press_flag <= 1'b0;
    end else begin
      if (key_sync == key_state) begin
        db_count <= '0;
      end else if (key_accept) begin
        key_state <= key_sync;
        db_count  <= '0;
      end else begin
        db_count <= db_count + 1'b1;
      end
      if (press_set) begin
        press_flag <= 1'b1;
      end else if (press_clear) begin
        press_flag <= 1'b0;
      end
    end
  end

endmodule
